// File: rtl/io_output_ctrl_pkg.sv
// Shared address-map tags, blank-digit constant, decode and byte-merge helpers
// for the memory-mapped I/O output controller.
// Pure declarations: no latency, no flow control.
package io_pkg;

  // Region tags compared against address bits [31:12].
  localparam logic [19:0] IO_LEDR_BASE   = 20'h10000;
  localparam logic [19:0] IO_LEDG_BASE   = 20'h10001;
  localparam logic [19:0] IO_HEXLO_BASE  = 20'h10002;
  localparam logic [19:0] IO_HEXHI_BASE  = 20'h10003;
  localparam logic [19:0] IO_LCD_BASE    = 20'h10004;
  localparam logic [19:0] IO_SW_BASE     = 20'h10010;
  localparam logic [19:0] IO_BTN_BASE    = 20'h10011;
  localparam logic [19:0] IO_BTNCAP_BASE = 20'h10012;

  // All segments off (segments are active-low).
  localparam logic [6:0] HEX_BLANK = 7'h7F;

  typedef enum logic [3:0] {
    RG_NONE,
    RG_LEDR,
    RG_LEDG,
    RG_HEXLO,
    RG_HEXHI,
    RG_LCD,
    RG_SW,
    RG_BTN,
    RG_BTNCAP
  } io_region_e;

  // HEX7-4 only exists on boards built with eight digits.
  function automatic io_region_e io_decode(input logic [19:0] tag, input int num_hex);
    io_region_e r;
    case (tag)
      IO_LEDR_BASE:   r = RG_LEDR;
      IO_LEDG_BASE:   r = RG_LEDG;
      IO_HEXLO_BASE:  r = RG_HEXLO;
      IO_HEXHI_BASE:  r = (num_hex == 8) ? RG_HEXHI : RG_NONE;
      IO_LCD_BASE:    r = RG_LCD;
      IO_SW_BASE:     r = RG_SW;
      IO_BTN_BASE:    r = RG_BTN;
      IO_BTNCAP_BASE: r = RG_BTNCAP;
      default:        r = RG_NONE;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] m);
    logic [31:0] bm;
    for (int i = 0; i < 4; i++) bm[8*i +: 8] = {8{m[i]}};
    return bm;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] m);
    return (old_w & ~byte_mask(m)) | (new_w & byte_mask(m));
  endfunction

endpackage

// File: rtl/io_output_ctrl_debounce.sv
// Two-flop synchroniser plus level debouncer for one asynchronous input.
// Latency: 2 sync cycles + DEB_CYCLES stable cycles before the level is accepted.
// No flow control; rise pulses for one cycle on the edge where stable goes 0->1.
// Ports: clk, reset (sync, active-low), din (raw pin), stable (debounced level), rise (accept-high strobe).
module io_debounce #(
  parameter int unsigned DEB_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // The toggle edge that takes stable from 0 to 1.
  assign rise = ~stable & sync2 & (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      // Any agreement restarts the count, so only an unbroken run of
      // DEB_CYCLES disagreeing cycles flips the output; cnt never wraps.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_output_ctrl.sv
// Memory-mapped I/O output registers (LEDR/LEDG/HEX/LCD), switch sync, button debounce and capture.
// Latency: stores land at the clock edge; loads return registered data one cycle after i_ld_en.
// No backpressure: every strobe is accepted; o_ld_valid pulses once per accepted load.
// Ports: i_clk/i_reset; store i_st_*; load i_ld_en/i_ld_addr -> o_ld_data/o_ld_valid/o_ld_err;
//        raw pins i_io_sw/i_io_btn; registered board outputs o_io_ledr/ledg/hex/lcd.
module io_output_ctrl
  import io_pkg::*;
#(
  parameter int          LEDR_W     = 17,
  parameter int          LEDG_W     = 8,
  parameter int          NUM_HEX    = 8,
  parameter int          SW_W       = 17,
  parameter int          BTN_W      = 4,
  parameter int unsigned DEB_CYCLES = 16'd50000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_st_en,
  input  logic [31:0]          i_st_addr,
  input  logic [31:0]          i_st_data,
  input  logic [3:0]           i_st_bmask,
  input  logic                 i_ld_en,
  input  logic [31:0]          i_ld_addr,
  output logic [31:0]          o_ld_data,
  output logic                 o_ld_valid,
  output logic                 o_ld_err,
  input  logic [SW_W-1:0]      i_io_sw,
  input  logic [BTN_W-1:0]     i_io_btn,
  output logic [LEDR_W-1:0]    o_io_ledr,
  output logic [LEDG_W-1:0]    o_io_ledg,
  output logic [NUM_HEX*7-1:0] o_io_hex,
  output logic [31:0]          o_io_lcd
);

  logic [LEDR_W-1:0] ledr;
  logic [LEDG_W-1:0] ledg;
  logic [3:0][6:0]   hex_lo;
  logic [31:0]       hex_lo_word;
  logic [31:0]       hex_hi_word;
  logic [31:0]       lcd;
  logic [SW_W-1:0]   sw_s1;
  logic [SW_W-1:0]   sw_s2;
  logic [BTN_W-1:0]  deb;
  logic [BTN_W-1:0]  deb_rise;
  logic [BTN_W-1:0]  cap;
  logic [BTN_W-1:0]  cap_clr;
  io_region_e        st_region;
  io_region_e        ld_region;
  logic [31:0]       ld_word;
  logic              ld_unmapped;
  logic              unused_addr_bits;

  assign st_region = io_decode(i_st_addr[31:12], NUM_HEX);
  assign ld_region = io_decode(i_ld_addr[31:12], NUM_HEX);
  assign unused_addr_bits = ^{i_st_addr[11:0], i_ld_addr[11:0]};

  // Digit n sits in byte n bits [6:0]; bit 7 is not stored and reads 0.
  assign hex_lo_word = {1'b0, hex_lo[3], 1'b0, hex_lo[2], 1'b0, hex_lo[1], 1'b0, hex_lo[0]};

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      ledr <= '0;
      ledg <= '0;
      lcd  <= '0;
      for (int n = 0; n < 4; n++) hex_lo[n] <= HEX_BLANK;
    end else if (i_st_en) begin
      case (st_region)
        RG_LEDR: ledr <= LEDR_W'(byte_merge(32'(ledr), i_st_data, i_st_bmask));
        RG_LEDG: ledg <= LEDG_W'(byte_merge(32'(ledg), i_st_data, i_st_bmask));
        RG_LCD:  lcd  <= byte_merge(lcd, i_st_data, i_st_bmask);
        RG_HEXLO: begin
          for (int n = 0; n < 4; n++)
            if (i_st_bmask[n]) hex_lo[n] <= i_st_data[8*n +: 7];
        end
        default: ;
      endcase
    end
  end

  if (NUM_HEX == 8) begin : g_hex_hi
    logic [3:0][6:0] hex_hi;

    always_ff @(posedge i_clk) begin
      if (!i_reset) begin
        for (int n = 0; n < 4; n++) hex_hi[n] <= HEX_BLANK;
      end else if (i_st_en && st_region == RG_HEXHI) begin
        for (int n = 0; n < 4; n++)
          if (i_st_bmask[n]) hex_hi[n] <= i_st_data[8*n +: 7];
      end
    end

    assign hex_hi_word = {1'b0, hex_hi[3], 1'b0, hex_hi[2], 1'b0, hex_hi[1], 1'b0, hex_hi[0]};
    assign o_io_hex    = {hex_hi, hex_lo};
  end else begin : g_hex_lo_only
    // Never selected by the load mux: the decoder reports HEX7-4 as unmapped.
    assign hex_hi_word = '0;
    assign o_io_hex    = hex_lo;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= i_io_sw;
      sw_s2 <= sw_s1;
    end
  end

  for (genvar b = 0; b < BTN_W; b++) begin : g_btn
    io_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (i_clk),
      .reset (i_reset),
      .din   (i_io_btn[b]),
      .stable(deb[b]),
      .rise  (deb_rise[b])
    );
  end

  // Write-1-to-clear; a press landing on the same edge as its clear wins.
  assign cap_clr = (i_st_en && st_region == RG_BTNCAP)
                 ? BTN_W'(i_st_data & byte_mask(i_st_bmask)) : '0;

  always_ff @(posedge i_clk) begin
    if (!i_reset) cap <= '0;
    else          cap <= (cap & ~cap_clr) | deb_rise;
  end

  // Reads sample pre-edge register state, giving read-before-write on collisions.
  always_comb begin
    ld_word     = '0;
    ld_unmapped = 1'b0;
    case (ld_region)
      RG_LEDR:   ld_word = 32'(ledr);
      RG_LEDG:   ld_word = 32'(ledg);
      RG_HEXLO:  ld_word = hex_lo_word;
      RG_HEXHI:  ld_word = hex_hi_word;
      RG_LCD:    ld_word = lcd;
      RG_SW:     ld_word = 32'(sw_s2);
      RG_BTN:    ld_word = 32'(deb);
      RG_BTNCAP: ld_word = 32'(cap);
      default:   ld_unmapped = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_ld_data  <= '0;
      o_ld_valid <= 1'b0;
      o_ld_err   <= 1'b0;
    end else begin
      o_ld_valid <= i_ld_en;
      if (i_ld_en) begin
        o_ld_data <= ld_word;
        o_ld_err  <= ld_unmapped;
      end
    end
  end

  assign o_io_ledr = ledr;
  assign o_io_ledg = ledg;
  assign o_io_lcd  = lcd;

endmodule

// File: tb/tb_io_output_ctrl.sv
module tb_io_output_ctrl;

  localparam logic [31:0] A_LEDR = 32'h1000_0000;
  localparam logic [31:0] A_LEDG = 32'h1000_1000;
  localparam logic [31:0] A_HLO  = 32'h1000_2000;
  localparam logic [31:0] A_HHI  = 32'h1000_3000;
  localparam logic [31:0] A_LCD  = 32'h1000_4000;
  localparam logic [31:0] A_UNM  = 32'h1000_5000;
  localparam logic [31:0] A_SW   = 32'h1001_0000;
  localparam logic [31:0] A_BTN  = 32'h1001_1000;
  localparam logic [31:0] A_CAP  = 32'h1001_2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic st_en, ld_en, st4_en, ld4_en;
  logic [31:0] st_addr, st_data, ld_addr, st4_addr, st4_data, ld4_addr;
  logic [3:0] st_bmask, st4_bmask;
  logic [31:0] ld_data, ld4_data, lcd, lcd4;
  logic ld_valid, ld_err, ld4_valid, ld4_err;
  logic [16:0] sw, ledr, ledr4;
  logic [3:0] btn;
  logic [7:0] ledg, ledg4;
  logic [55:0] hex;
  logic [27:0] hex4;

  io_output_ctrl #(.NUM_HEX(8), .DEB_CYCLES(8)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_st_en(st_en), .i_st_addr(st_addr), .i_st_data(st_data), .i_st_bmask(st_bmask),
    .i_ld_en(ld_en), .i_ld_addr(ld_addr),
    .o_ld_data(ld_data), .o_ld_valid(ld_valid), .o_ld_err(ld_err),
    .i_io_sw(sw), .i_io_btn(btn),
    .o_io_ledr(ledr), .o_io_ledg(ledg), .o_io_hex(hex), .o_io_lcd(lcd)
  );

  io_output_ctrl #(.NUM_HEX(4), .DEB_CYCLES(8)) dut4 (
    .i_clk(clk), .i_reset(rst_n),
    .i_st_en(st4_en), .i_st_addr(st4_addr), .i_st_data(st4_data), .i_st_bmask(st4_bmask),
    .i_ld_en(ld4_en), .i_ld_addr(ld4_addr),
    .o_ld_data(ld4_data), .o_ld_valid(ld4_valid), .o_ld_err(ld4_err),
    .i_io_sw(sw), .i_io_btn(btn),
    .o_io_ledr(ledr4), .o_io_ledg(ledg4), .o_io_hex(hex4), .o_io_lcd(lcd4)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
    int          tag;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int tag_n = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Response monitors: pop the oldest expectation whenever a load response appears.
  always @(negedge clk) begin
    exp_t e;
    if (ld_valid === 1'b1) begin
      if (q8.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL dut8 unrequested load response: data 0x%0h", ld_data);
      end else begin
        e = q8.pop_front();
        check($sformatf("dut8 ld%0d data", e.tag), ld_data, e.data);
        check($sformatf("dut8 ld%0d err", e.tag), ld_err, e.err);
        check($sformatf("dut8 ld%0d latency", e.tag), cyc - e.cyc, 1);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ld4_valid === 1'b1) begin
      if (q4.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL dut4 unrequested load response: data 0x%0h", ld4_data);
      end else begin
        e = q4.pop_front();
        check($sformatf("dut4 ld%0d data", e.tag), ld4_data, e.data);
        check($sformatf("dut4 ld%0d err", e.tag), ld4_err, e.err);
        check($sformatf("dut4 ld%0d latency", e.tag), cyc - e.cyc, 1);
      end
    end
  end

  task automatic store(input bit d4, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    if (d4) begin st4_en = 1'b1; st4_addr = a; st4_data = d; st4_bmask = m; end
    else    begin st_en  = 1'b1; st_addr  = a; st_data  = d; st_bmask  = m; end
    @(negedge clk);
    st_en  = 1'b0;
    st4_en = 1'b0;
  endtask

  task automatic push_exp(input bit d4, input logic [31:0] d, input logic e);
    exp_t x;
    x.data = d; x.err = e; x.cyc = cyc; x.tag = tag_n;
    tag_n++;
    if (d4) q4.push_back(x);
    else    q8.push_back(x);
  endtask

  task automatic load(input bit d4, input logic [31:0] a, input logic [31:0] d, input logic e);
    @(negedge clk);
    if (d4) begin ld4_en = 1'b1; ld4_addr = a; end
    else    begin ld_en  = 1'b1; ld_addr  = a; end
    push_exp(d4, d, e);
    @(negedge clk);
    ld_en  = 1'b0;
    ld4_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [55:0] hexp;
    rst_n = 1'b0;
    st_en = 0; ld_en = 0; st4_en = 0; ld4_en = 0;
    st_addr = 0; st_data = 0; st_bmask = 0; ld_addr = 0;
    st4_addr = 0; st4_data = 0; st4_bmask = 0; ld4_addr = 0;
    sw = '0; btn = '0;
    repeat (3) @(negedge clk);
    check("reset hex", hex, {8{7'h7F}});
    check("reset hex4", hex4, {4{7'h7F}});
    check("reset ledr", ledr, 0);
    check("reset ledg", ledg, 0);
    check("reset lcd", lcd, 0);
    check("reset ld_valid", ld_valid, 0);
    check("reset ld_data", ld_data, 0);
    check("reset ld_err", ld_err, 0);
    rst_n = 1'b1;

    load(0, A_HLO, 32'h7F7F7F7F, 0);
    load(0, A_HHI, 32'h7F7F7F7F, 0);

    store(0, A_HLO, 32'hAABBCCDD, 4'b0010);
    hexp = {8{7'h7F}};
    hexp[13:7] = 7'h4C;
    check("hex1 byte store", hex, hexp);
    load(0, A_HLO, 32'h7F7F4C7F, 0);

    store(0, A_LEDR, 32'hFFFFFFFF, 4'hF);
    check("ledr full store", ledr, 17'h1FFFF);
    load(0, A_LEDR, 32'h0001FFFF, 0);
    repeat (2) @(negedge clk);
    check("ld_data hold", ld_data, 32'h0001FFFF);
    check("ld_valid idle", ld_valid, 0);

    // Store and load LEDG on the same edge: the load sees the old value.
    @(negedge clk);
    st_en = 1; st_addr = A_LEDG; st_data = 32'h5; st_bmask = 4'hF;
    ld_en = 1; ld_addr = A_LEDG;
    push_exp(0, 32'h0, 0);
    @(negedge clk);
    st_en = 0; ld_en = 0;
    load(0, A_LEDG, 32'h5, 0);
    check("ledg after store", ledg, 8'h05);

    store(0, A_LCD, 32'h12345678, 4'b1001);
    check("lcd byte mask", lcd, 32'h12000078);
    load(0, A_LCD | 32'hABC, 32'h12000078, 0);

    load(0, A_UNM, 32'h0, 1);
    store(0, A_SW, 32'hFFFFFFFF, 4'hF);
    store(0, A_UNM, 32'hFFFFFFFF, 4'hF);
    store(0, A_LEDG, 32'hFF, 4'h0);
    check("ledr untouched", ledr, 17'h1FFFF);
    check("ledg mask-0 no-op", ledg, 8'h05);

    store(1, A_HHI, 32'h11223344, 4'hF);
    check("dut4 hex hi ignored", hex4, {4{7'h7F}});
    load(1, A_HHI, 32'h0, 1);
    store(1, A_HLO, 32'h00000012, 4'b0001);
    load(1, A_HLO, 32'h7F7F7F12, 0);

    @(negedge clk);
    sw = 17'h15A5A;
    repeat (3) @(negedge clk);
    load(0, A_SW, 32'h00015A5A, 0);

    // Short glitch: five cycles is below the debounce window.
    @(negedge clk);
    btn[0] = 1'b1;
    repeat (5) @(negedge clk);
    btn[0] = 1'b0;
    repeat (15) @(negedge clk);
    load(0, A_BTN, 32'h0, 0);
    load(0, A_CAP, 32'h0, 0);

    // Held level: accepted on the tenth edge after the pin changes.
    @(negedge clk);
    btn[0] = 1'b1;
    repeat (7) @(negedge clk);
    load(0, A_BTN, 32'h0, 0);
    load(0, A_BTN, 32'h1, 0);
    load(0, A_CAP, 32'h1, 0);
    repeat (7) @(negedge clk);
    btn[0] = 1'b0;
    repeat (15) @(negedge clk);
    load(0, A_BTN, 32'h0, 0);
    load(0, A_CAP, 32'h1, 0);

    store(0, A_CAP, 32'h0, 4'hF);
    load(0, A_CAP, 32'h1, 0);
    store(0, A_CAP, 32'h1, 4'b0001);
    load(0, A_CAP, 32'h0, 0);

    // Clear lands on the same edge as the new press: the set wins.
    @(negedge clk);
    btn[0] = 1'b1;
    repeat (8) @(negedge clk);
    store(0, A_CAP, 32'h1, 4'b0001);
    load(0, A_CAP, 32'h1, 0);
    btn[0] = 1'b0;
    repeat (15) @(negedge clk);

    // Reset part-way through a debounce count, with a load in flight.
    @(negedge clk);
    btn[0] = 1'b1;
    repeat (6) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    ld_en = 1'b1; ld_addr = A_LEDR;
    @(negedge clk);
    ld_en = 1'b0;
    rst_n = 1'b1;
    check("ld_valid dropped by reset", ld_valid, 0);
    check("ledr after mid reset", ledr, 0);
    check("deb counter after reset", dut.g_btn[0].u_deb.cnt, 0);
    load(0, A_CAP, 32'h0, 0);
    load(0, A_BTN, 32'h0, 0);
    repeat (3) @(negedge clk);
    load(0, A_BTN, 32'h0, 0);
    load(0, A_BTN, 32'h1, 0);

    repeat (5) @(negedge clk);
    check("dut8 responses drained", q8.size(), 0);
    check("dut4 responses drained", q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_output_ctrl.md
Name: io_output_ctrl

Overview:
- Parametrised successor to the combinational I/O load mux.
- Owns the memory-mapped I/O output registers (LEDR, LEDG, HEX banks, LCD) with byte-masked stores and a registered one-cycle load path.
- Synchronises switches; synchronises and debounces buttons, with a sticky press-capture register.
- Sits between the LSU's I/O-valid path and the board pins; DMEM/IO selection stays in the LSU.

Parameters:
- LEDR_W, 17, red LED count (1..32)
- LEDG_W, 8, green LED count (1..32)
- NUM_HEX, 8, 7-segment digits; legal values 4 or 8
- SW_W, 17, switch count (1..32)
- BTN_W, 4, button count (1..32)
- DEB_CYCLES, 16'd50000, cycles a synced button must hold a new level before it is accepted (>=2)

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-low reset
- i_st_en  in  1  I/O store strobe
- i_st_addr  in  32  store address
- i_st_data  in  32  store data
- i_st_bmask  in  4  byte enables; bit n covers data[8n+7:8n]
- i_ld_en  in  1  I/O load strobe
- i_ld_addr  in  32  load address
- o_ld_data  out  32  registered load data
- o_ld_valid  out  1  high one cycle after an accepted i_ld_en
- o_ld_err  out  1  with o_ld_valid: address unmapped
- i_io_sw  in  SW_W  raw switches, asynchronous
- i_io_btn  in  BTN_W  raw buttons, asynchronous, active-high pressed
- o_io_ledr  out  LEDR_W  red LEDs
- o_io_ledg  out  LEDG_W  green LEDs
- o_io_hex  out  NUM_HEX x 7  digit k = segments, active-low
- o_io_lcd  out  32  LCD control word

Behaviour:
- Clock and reset: one clock, i_clk. Synchronous active-low reset on i_reset. All state is updated on the rising edge.
- Reset values: LEDR, LEDG, LCD = 0; every hex digit = 7'h7F (blank); o_ld_data = 0; o_ld_valid = 0; o_ld_err = 0; synchronisers = 0; debounced buttons = 0; debounce counters = 0; capture register = 0.
- Reset asserted mid-operation drops any pending load response. o_ld_valid is 0 on the cycle after reset.
- Address map (decode [31:12]):
  - 0x10000 LEDR
  - 0x10001 LEDG
  - 0x10002 HEX3-0
  - 0x10003 HEX7-4 (mapped only when NUM_HEX=8)
  - 0x10004 LCD
  - 0x10010 SW (read-only)
  - 0x10011 BTN debounced (read-only)
  - 0x10012 BTN capture (read; write-1-to-clear)
- Address bits [11:0] are ignored.
- HEX word layout: digit n occupies byte n, bits [6:0]. Bit 7 of each byte is not stored and reads 0.
- Stores: on i_st_en, each enabled byte of the decoded register is updated at the edge.
  - Bits at or above the register width are discarded.
  - Stores to read-only or unmapped addresses are ignored; they raise no error and change no state.
  - A store with all mask bits 0 is a no-op.
- Loads: on i_ld_en, o_ld_data/o_ld_valid/o_ld_err are registered next cycle (latency 1).
  - The value is zero-extended to 32 bits.
  - Unmapped address: data 0, err 1.
  - When i_ld_en is low, o_ld_valid is 0 and o_ld_data holds its previous value.
- Simultaneous load and store to the same register: the load returns the pre-store value (read-before-write).
- Simultaneous capture clear and new press on the same bit: the set wins.
- Switches: 2-flop synchroniser. A SW read returns the synchronised value, 2-3 cycles behind the pin.
- Buttons: 2-flop synchroniser, then a per-bit debounce counter.
  - When the synced bit equals the debounced bit, the counter resets to 0.
  - Otherwise the counter increments; when it reaches DEB_CYCLES-1 the debounced bit toggles and the counter returns to 0.
  - A glitch shorter than DEB_CYCLES cycles never changes the debounced value.
  - Counter width = $clog2(DEB_CYCLES)+1. The counter never wraps.
- Capture: a bit is set on a debounced 0->1 transition and stays set until written 1. Writing 0 leaves the bit unchanged.
- Outputs o_io_* are driven directly from the registers (registered outputs, no combinational path from the store inputs).

Decomposition:
- Package io_pkg holds:
  - region constants (IO_LEDR_BASE .. IO_BTNCAP_BASE, 20-bit tags)
  - HEX_BLANK = 7'h7F
  - enum io_region_e for decode results
- One sub-module, io_debounce (parametrised by DEB_CYCLES). It contains the synchroniser, counter and stable bit for a single input, and is instantiated BTN_W times via generate.

Test Plan:
- Reset then read: load 0x1000_2000 -> o_ld_data 0x7F7F7F7F, o_ld_valid one cycle later; every o_io_hex digit = 7'h7F.
- Byte store: store 0xAABBCCDD, mask 4'b0010 to 0x1000_2000 -> hex1 = 7'h4C, other digits stay 7'h7F. Store 0xFFFFFFFF to LEDR -> o_io_ledr = 17'h1FFFF; readback 0x0001FFFF.
- Same-cycle load and store: store 0x5 and load LEDG in the same cycle -> returned data is the old value 0. The next load returns 0x5.
- Unmapped and parameter checks: load 0x1000_5000 -> data 0, err 1. With NUM_HEX=4, 0x1000_3000 is unmapped and stores to it are ignored.
- Debounce (DEB_CYCLES=8): a 5-cycle btn[0] pulse -> debounced and capture stay 0. A level held for 20 cycles -> debounced bit 1 about 10 cycles after the edge, capture bit 0 set.
- Capture clear: write 0x1 to 0x1001_2000 -> capture 0. A clear coinciding with a new press edge -> bit stays 1. Reset mid-count -> counter and debounced value return to 0.
